clock_divider_bank: RTL and testbench
=====================================

# clock_divider_bank

Parametrised multi-channel clock divider driven from the board clock. It generates `CHANNELS` independent square waves plus one-cycle tick strobes for the display-scan and sampling logic. Each channel has a runtime-loadable divisor, a per-channel enable, and a common phase-aligning restart. Counts are exact: a divisor of N yields a period of exactly N `BoardCLK` cycles. Outputs are registered, so they are glitch-free for use as enables or slow clocks.

## Interface
- `CHANNELS`, 2, number of divider channels (1..16)
- `CNT_W`, 18, counter and divisor width per channel; must hold N-1 for every divisor used
- `DEFAULT_DIV`, {18'd5000, 18'd200000}, flat `CHANNELS*CNT_W` vector of reset divisors, channel 0 in the LSBs (at 50 MHz: ch0 250 Hz, ch1 10 kHz)

Ports:
- `BoardCLK` in 1: the only clock; all logic is on the rising edge
- `Reset` in 1: synchronous, active-high reset
- `Enable` in `CHANNELS`: per-channel count enable
- `DivIn` in `CHANNELS*CNT_W`: new divisors, same packing as `DEFAULT_DIV`
- `DivLoad` in 1: one-cycle strobe that latches `DivIn` and restarts all channels
- `SyncRestart` in 1: one-cycle strobe that restarts all channels and keeps the current divisors
- `ClkOut` out `CHANNELS`: divided square wave per channel
- `TickOut` out `CHANNELS`: one-cycle pulse coinciding with each rising edge of `ClkOut`

## Operation
- Per channel state: active divisor `D` (`CNT_W`), counter `C` (`CNT_W`), registered `ClkOut`, registered `TickOut`.
- Define H = floor(D/2).
- Counting edge (`Enable`=1 and D≥2):
  - C <= (C == D-1) ? 0 : C+1.
  - If C == D-1: `ClkOut` <= 1 and `TickOut` <= 1.
  - Else if C == H-1: `ClkOut` <= 0 and `TickOut` <= 0.
  - Otherwise `TickOut` <= 0 and `ClkOut` holds.
- Result: high for H cycles, low for D-H cycles. Odd D gives the longer half low. D=2 gives a 50% toggle every cycle.
- `Enable`=0: C and `ClkOut` freeze; `TickOut` <= 0.
- D<2 (0 or 1): channel idle. C <= 0, `ClkOut` <= 0, `TickOut` <= 0 regardless of `Enable`.
- Restart (via `DivLoad` or `SyncRestart`): every channel sets C <= 0, `ClkOut` <= 0, `TickOut` <= 0 on the same edge. All channels are then phase-aligned.
- `DivLoad`: additionally D <= `DivIn` slice for every channel on that edge. `DivIn` is sampled only when `DivLoad`=1.
- Priority on any edge: `Reset` > `DivLoad` > `SyncRestart` > normal counting.
- Channels are fully independent apart from the shared restart and load.

## Timing
- Reset values:
  - D = `DEFAULT_DIV` slice
  - C = 0
  - `ClkOut` = 0
  - `TickOut` = 0
- The first `TickOut` and `ClkOut` rise occur on the Nth enabled edge after `Reset`, restart or load deasserts (edges counted from 1). They are visible in the following cycle.
- Steady state: `TickOut` is high exactly 1 cycle in every D enabled cycles. The `ClkOut` rising edge and the `TickOut` rise appear in the same cycle.
- Reset mid-period: outputs are forced low on the next edge. There is no partial pulse afterwards.
- `DivLoad` mid-period: the old period is abandoned. The new period starts from C=0 with no runt high pulse. The low phase can be shortened, which is acceptable and documented.
- `Enable` deasserted while `ClkOut`=1 stretches the high phase. Re-enabling resumes from the frozen C.
- Latency from any strobe to outputs: 1 cycle.

## Test plan
- Reset, D0=4, D1=5, all enabled. Required response:
  - ch0 `ClkOut` pattern after the first rise: 1100 repeating.
  - ch1 pattern: 11000 repeating.
  - `TickOut` period 4 on ch0 and 5 on ch1.
  - First ch0 tick visible 4 cycles after `Reset` falls.
- D0=2: ch0 `ClkOut` toggles every cycle, and `TickOut` is high every other cycle.
- D0=6, `Enable[0]` low for 3 cycles while high: the high phase lasts 6 cycles instead of 3. `TickOut` stays 0 during the hold, and the period resumes at 6.
- `DivLoad` with `DivIn` = {5'd3, 5'd7} mid-period, `CNT_W`=5: both outputs are 0 on the next cycle. ch0 then ticks every 7 cycles and ch1 every 3, with first ticks 7 and 3 cycles after the load.
- D0=0 and D0=1 loaded: ch0 `ClkOut` and `TickOut` stay 0 for 50 cycles. ch1 is unaffected.
- `Reset` and `DivLoad` asserted together: the default divisors are used, not `DivIn`. `SyncRestart` alone realigns the ticks of two channels with divisors 3 and 6, so every second ch0 tick coincides with a ch1 tick.

Source files
------------

// File: rtl/clock_divider_bank_if.sv
// Purpose : control/status bundle for clock_divider_bank (enables, divisor load, restart, divided outputs).
// Latency : wires only; the divider registers everything one BoardCLK edge after the strobe.
// Backpressure: none; every strobe is accepted on the edge it is sampled.
//
// Signals:
//   Enable      [CHANNELS]        per-channel count enable
//   DivIn       [CHANNELS*CNT_W]  new divisors, channel 0 in the LSBs
//   DivLoad                       one-cycle strobe: latch DivIn and restart all channels
//   SyncRestart                   one-cycle strobe: restart all channels, keep divisors
//   ClkOut      [CHANNELS]        divided square waves
//   TickOut     [CHANNELS]        one-cycle pulse on each ClkOut rise
interface clock_divider_bank_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 18
);
    logic [CHANNELS-1:0]       Enable;
    logic [CHANNELS*CNT_W-1:0] DivIn;
    logic                      DivLoad;
    logic                      SyncRestart;
    logic [CHANNELS-1:0]       ClkOut;
    logic [CHANNELS-1:0]       TickOut;

    // master drives the controls and observes the divided outputs
    modport master (
        output Enable,
        output DivIn,
        output DivLoad,
        output SyncRestart,
        input  ClkOut,
        input  TickOut
    );

    // slave is the divider bank itself
    modport slave (
        input  Enable,
        input  DivIn,
        input  DivLoad,
        input  SyncRestart,
        output ClkOut,
        output TickOut
    );
endinterface

// File: rtl/clock_divider_bank.sv
// Purpose : CHANNELS independent exact-period clock dividers with registered square wave and tick outputs.
// Latency : 1 BoardCLK cycle from any strobe (Reset, DivLoad, SyncRestart, Enable) to ClkOut/TickOut.
// Backpressure: none; strobes are taken every cycle, Enable=0 simply freezes a channel.
//
// Ports:
//   BoardCLK  in   board clock, all state on its rising edge
//   Reset     in   synchronous active-high reset (divisors return to DEFAULT_DIV)
//   bus       slave modport of clock_divider_bank_if (controls in, ClkOut/TickOut out)
//
// A divisor D gives a period of exactly D cycles: high for floor(D/2), low for the rest.
// D of 0 or 1 parks the channel with both outputs low.
module clock_divider_bank #(
    parameter int                        CHANNELS    = 2,
    parameter int                        CNT_W       = 18,
    parameter logic [CHANNELS*CNT_W-1:0] DEFAULT_DIV = {18'd5000, 18'd200000}
) (
    input  logic                  BoardCLK,
    input  logic                  Reset,
    clock_divider_bank_if.slave   bus
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [CNT_W-1:0]    div_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CHANNELS-1:0] clk_q;
    logic [CHANNELS-1:0] tick_q;

    // per-channel decode of the current count
    logic [CHANNELS-1:0] at_last;   // C == D-1: end of period, output rises next
    logic [CHANNELS-1:0] at_half;   // C == floor(D/2)-1: end of high phase
    logic [CHANNELS-1:0] running;   // D >= 2, channel can produce a waveform

    always_comb begin
        at_last = '0;
        at_half = '0;
        running = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            at_last[i] = (cnt_q[i] == (div_q[i] - ONE));
            // With D >= 2 the two compare points never coincide, so the rise wins only by order.
            at_half[i] = (cnt_q[i] == ((div_q[i] >> 1) - ONE));
            running[i] = (div_q[i] >= TWO);
        end
    end

    always_ff @(posedge BoardCLK) begin
        if (Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= DEFAULT_DIV[i*CNT_W +: CNT_W];
                cnt_q[i] <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
        end else if (bus.DivLoad) begin
            // New divisors start from a clean low phase on every channel at once.
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= bus.DivIn[i*CNT_W +: CNT_W];
                cnt_q[i] <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
        end else if (bus.SyncRestart) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!running[i]) begin
                    // Degenerate divisor: hold the channel idle regardless of Enable.
                    cnt_q[i]  <= '0;
                    clk_q[i]  <= 1'b0;
                    tick_q[i] <= 1'b0;
                end else if (bus.Enable[i]) begin
                    if (at_last[i]) begin
                        cnt_q[i]  <= '0;
                        clk_q[i]  <= 1'b1;
                        tick_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + ONE;
                        tick_q[i] <= 1'b0;
                        if (at_half[i]) begin
                            clk_q[i] <= 1'b0;
                        end
                    end
                end else begin
                    // Frozen: count and level hold, which stretches whichever phase is active.
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.ClkOut  = clk_q;
    assign bus.TickOut = tick_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

    localparam int CHANNELS = 2;
    localparam int CNT_W    = 5;

    logic BoardCLK = 1'b0;
    logic Reset;

    int checks   = 0;
    int failures = 0;

    clock_divider_bank_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

    // Reset divisors: ch0 = 4, ch1 = 5
    clock_divider_bank #(
        .CHANNELS   (CHANNELS),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV({5'd5, 5'd4})
    ) dut (
        .BoardCLK (BoardCLK),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 BoardCLK = ~BoardCLK;

    // Watchdog so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge; inputs changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge BoardCLK);
        #1;
    endtask

    // obs/exp packing: {ClkOut[1], ClkOut[0], TickOut[1], TickOut[0]}
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.ClkOut[1], bus.ClkOut[0], bus.TickOut[1], bus.TickOut[0]};
    endfunction

    // Run len(c0) edges; character i of each string is the level expected after edge i+1.
    task automatic expect_seq(input string tag, input string c0, input string t0,
                              input string c1, input string t1);
        logic [3:0] e;
        for (int i = 0; i < c0.len(); i++) begin
            step();
            e = {c1[i] == "1", c0[i] == "1", t1[i] == "1", t0[i] == "1"};
            chk($sformatf("%s[%0d]", tag, i + 1), outs(), e);
        end
    endtask

    // One-edge divisor load; DivIn is scrambled afterwards since it must only be sampled on the strobe.
    task automatic load(input string tag, input logic [4:0] d1, input logic [4:0] d0);
        bus.DivIn   = {d1, d0};
        bus.DivLoad = 1'b1;
        step();
        chk(tag, outs(), 4'b0000);
        bus.DivLoad = 1'b0;
        bus.DivIn   = '1;
    endtask

    initial begin
        Reset           = 1'b1;
        bus.Enable      = 2'b11;
        bus.DivIn       = '1;
        bus.DivLoad     = 1'b0;
        bus.SyncRestart = 1'b0;

        // Reset state
        step();
        step();
        chk("reset", outs(), 4'b0000);
        Reset = 1'b0;

        // Default divisors 4 and 5: ch0 1100..., ch1 11000..., first ch0 tick 4 edges after reset
        expect_seq("dflt",
                   "000110011001", "000100010001",
                   "000011000110", "000010000100");

        // D0 = 2: toggle every edge
        load("load_d2", 5'd5, 5'd2);
        expect_seq("d2",
                   "0101010101", "0101010101",
                   "0000110001", "0000100001");

        // D0 = 6 with Enable[0] dropped for 3 edges during the high phase
        load("load_d6", 5'd5, 5'd6);
        expect_seq("d6_pre",  "000001", "000001", "000011", "000010");
        bus.Enable = 2'b10;
        expect_seq("d6_hold", "111",    "000",    "000",    "000");
        bus.Enable = 2'b11;
        expect_seq("d6_post", "110001110", "000001000", "110001100", "100001000");

        // Get ch1 high, then load mid-period: outputs clear on the load edge with no runt
        expect_seq("pre_load", "00", "00", "01", "01");
        load("load_7_3", 5'd3, 5'd7);
        expect_seq("d7_d3",
                   "000000111000011", "000000100000010",
                   "001001001001001", "001001001001001");

        // Degenerate ch0 divisors 0 then 1: ch0 silent 50 cycles, ch1 keeps running at 3
        load("load_d0", 5'd3, 5'd0);
        expect_seq("d0",
                   "0000000000000000000000000", "0000000000000000000000000",
                   "0010010010010010010010010", "0010010010010010010010010");
        load("load_d1", 5'd3, 5'd1);
        expect_seq("d1",
                   "0000000000000000000000000", "0000000000000000000000000",
                   "0010010010010010010010010", "0010010010010010010010010");

        // Reset beats DivLoad: defaults 4/5 come back, not DivIn
        Reset       = 1'b1;
        bus.DivLoad = 1'b1;
        bus.DivIn   = {5'd3, 5'd3};
        step();
        chk("rst_vs_load", outs(), 4'b0000);
        Reset       = 1'b0;
        bus.DivLoad = 1'b0;
        bus.DivIn   = '1;
        expect_seq("rst_dflt",
                   "000110011001", "000100010001",
                   "000011000110", "000010000100");

        // Divisors 3 and 6, knocked out of phase by holding ch1, then realigned by SyncRestart
        load("load_3_6", 5'd6, 5'd3);
        expect_seq("sr_pre", "0010", "0010", "0000", "0000");
        bus.Enable = 2'b01;
        expect_seq("sr_skew", "01", "01", "00", "00");
        bus.Enable      = 2'b11;
        bus.SyncRestart = 1'b1;
        step();
        chk("sync_restart", outs(), 4'b0000);
        bus.SyncRestart = 1'b0;
        expect_seq("sr_align",
                   "001001001001", "001001001001",
                   "000001110001", "000001000001");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
